// File: rtl/ifetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
package ifetch_pkg;

    localparam int unsigned IF_SLOTS = 2;
    localparam int unsigned SLOT_CUR = 0;
    localparam int unsigned SLOT_NXT = 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } fsm_t;

    // Increment modulo 2^(pmsb+1); the caller narrows the result to its PC width.
    function automatic logic [31:0] inc_pc(input logic [31:0] pc, input int unsigned pmsb);
        logic [31:0] mask;
        mask = (pmsb >= 32'd31) ? 32'hFFFF_FFFF : ((32'd1 << (pmsb + 32'd1)) - 32'd1);
        return (pc + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Program-memory req/ack bus between the fetch stage and instruction memory.
interface ifetch_if #(
    parameter int unsigned IMSB = 15,
    parameter int unsigned PMSB = 7
);
    logic          req;
    logic [PMSB:0] addr;
    logic          ack;
    logic [IMSB:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/ifetch_slot.sv
// One buffer entry: valid/tag/data register with load (priority), clear and tag compare.
module ifetch_slot #(
    parameter int unsigned IMSB = 15,
    parameter int unsigned PMSB = 7
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load,
    input  logic          clear,
    input  logic [PMSB:0] load_tag,
    input  logic [IMSB:0] load_data,
    input  logic [PMSB:0] cmp_tag,
    output logic          vld,
    output logic [PMSB:0] tag,
    output logic [IMSB:0] data,
    output logic          hit_c
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld  <= 1'b0;
            tag  <= '0;
            data <= '0;
        end else if (load) begin
            vld  <= 1'b1;
            tag  <= load_tag;
            data <= load_data;
        end else if (clear) begin
            vld  <= 1'b0;
        end
    end

    assign hit_c = vld && (tag == cmp_tag);

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: two-entry buffer (current + sequential prefetch) in front of
// a variable-latency program memory; a tag mismatch against pc flushes the buffer.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int unsigned IMSB = 15,
    parameter int unsigned PMSB = 7
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [PMSB:0] pc,
    output logic [IMSB:0] inst,
    output logic          setn,
    ifetch_if.master      mem
);

    localparam int unsigned PW = PMSB + 1;

    fsm_t          state;
    logic [PMSB:0] req_tag;

    logic          s_load    [IF_SLOTS];
    logic          s_clear   [IF_SLOTS];
    logic [PMSB:0] s_ld_tag  [IF_SLOTS];
    logic [IMSB:0] s_ld_data [IF_SLOTS];
    logic [PMSB:0] s_cmp     [IF_SLOTS];
    logic          s_vld     [IF_SLOTS];
    logic [PMSB:0] s_tag     [IF_SLOTS];
    logic [IMSB:0] s_data    [IF_SLOTS];
    logic          s_hit     [IF_SLOTS];

    logic          hit, nxt_match, flush, fill, fill_cur, fill_nxt;
    logic          need_any, need_any_n;
    logic          cur_v_n, nxt_v_n, cur_ok_n, nxt_ok_n;
    logic [PMSB:0] pc1, target, target_n, pc_n, pc_n1, cur_tag_n, nxt_tag_n;

    assign pc1            = PW'(inc_pc(32'(pc), PMSB));
    assign s_cmp[SLOT_CUR] = pc;
    assign s_cmp[SLOT_NXT] = pc1;

    for (genvar i = 0; i < int'(IF_SLOTS); i++) begin : g_slot
        ifetch_slot #(.IMSB(IMSB), .PMSB(PMSB)) u_slot (
            .clk       (clk),
            .rstn      (rstn),
            .load      (s_load[i]),
            .clear     (s_clear[i]),
            .load_tag  (s_ld_tag[i]),
            .load_data (s_ld_data[i]),
            .cmp_tag   (s_cmp[i]),
            .vld       (s_vld[i]),
            .tag       (s_tag[i]),
            .data      (s_data[i]),
            .hit_c     (s_hit[i])
        );
    end

    // Slot update: flush, then consume, then a memory fill that may override both.
    always_comb begin
        hit       = s_hit[SLOT_CUR];
        nxt_match = s_hit[SLOT_NXT];
        flush     = s_vld[SLOT_CUR] && !hit;
        fill      = mem.ack && (state == BUSY);
        fill_cur  = fill && (((req_tag == pc) && !hit) || ((req_tag == pc1) && hit));
        fill_nxt  = fill && !hit && (req_tag == pc1);

        s_load[SLOT_CUR]    = fill_cur || (hit && nxt_match);
        s_clear[SLOT_CUR]   = flush || hit;
        s_ld_tag[SLOT_CUR]  = fill_cur ? req_tag : s_tag[SLOT_NXT];
        s_ld_data[SLOT_CUR] = fill_cur ? mem.rdata : s_data[SLOT_NXT];

        s_load[SLOT_NXT]    = fill_nxt;
        s_clear[SLOT_NXT]   = flush || hit;
        s_ld_tag[SLOT_NXT]  = req_tag;
        s_ld_data[SLOT_NXT] = mem.rdata;
    end

    // Fetch need now (IDLE launch) and after this edge's slot update (BUSY re-issue).
    always_comb begin
        need_any  = !hit || !nxt_match;
        target    = hit ? pc1 : pc;

        cur_v_n   = s_load[SLOT_CUR] || (!s_clear[SLOT_CUR] && s_vld[SLOT_CUR]);
        cur_tag_n = s_load[SLOT_CUR] ? s_ld_tag[SLOT_CUR] : s_tag[SLOT_CUR];
        nxt_v_n   = s_load[SLOT_NXT] || (!s_clear[SLOT_NXT] && s_vld[SLOT_NXT]);
        nxt_tag_n = s_load[SLOT_NXT] ? s_ld_tag[SLOT_NXT] : s_tag[SLOT_NXT];

        pc_n       = hit ? pc1 : pc;
        pc_n1      = PW'(inc_pc(32'(pc_n), PMSB));
        cur_ok_n   = cur_v_n && (cur_tag_n == pc_n);
        nxt_ok_n   = nxt_v_n && (nxt_tag_n == pc_n1);
        need_any_n = !cur_ok_n || !nxt_ok_n;
        target_n   = cur_ok_n ? pc_n1 : pc_n;
    end

    // Request FSM: at most one outstanding request, address frozen until ack.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            req_tag <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (need_any) begin
                        req_tag <= target;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem.ack) begin
                        if (need_any_n) begin
                            req_tag <= target_n;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign setn     = hit;
    assign inst     = s_data[SLOT_CUR];
    assign mem.req  = (state == BUSY);
    assign mem.addr = req_tag;

endmodule
